// File: rtl/xnor_stream_correlator.sv
// Serial XNOR pattern correlator: scores each W-bit window of an accepted bit stream
// against a reference pattern, pulses match on score >= thresh, with hold-off and hit counter.
module xnor_stream_correlator #(
    parameter int W       = 8,
    parameter int HOLDOFF = 8,
    parameter int CW      = 8,
    localparam int SW     = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          bit_valid,
    input  logic          bit_in,
    input  logic [W-1:0]  pattern,
    input  logic [SW-1:0] thresh,
    output logic [SW-1:0] score,
    output logic          score_valid,
    output logic          match,
    output logic [CW-1:0] hit_count,
    output logic [1:0]    state_o
);
    localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [SW-1:0] FILL_MAX = SW'(W);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLDOFF);

    typedef enum logic [1:0] {FILL = 2'd0, SEARCH = 2'd1, HOLD = 2'd2} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  shreg, shreg_n;
    logic [SW-1:0] fill, fill_n, score_n;
    logic [HW-1:0] hold, hold_n;
    logic          eval, hit;

    function automatic logic [SW-1:0] popcount(input logic [W-1:0] v);
        logic [SW-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) c = c + SW'(v[i]);
        return c;
    endfunction

    always_comb begin
        shreg_n  = {shreg[W-2:0], bit_in};
        fill_n   = (fill == FILL_MAX) ? fill : fill + 1'b1;
        score_n  = popcount(~(shreg_n ^ pattern));
        // The bit that completes the first window is evaluated under the SEARCH rule.
        eval     = bit_valid && ((state != FILL) || (fill_n == FILL_MAX));
        hit      = 1'b0;
        state_nx = state;
        hold_n   = hold;
        if (eval) begin
            case (state)
                FILL, SEARCH: begin
                    state_nx = SEARCH;
                    if (score_n >= thresh) begin
                        hit = 1'b1;
                        if (HOLDOFF > 0) begin
                            state_nx = HOLD;
                            hold_n   = '0;
                        end
                    end
                end
                HOLD: begin
                    hold_n = hold + 1'b1;
                    if (hold_n == HOLD_MAX) state_nx = SEARCH;
                end
                default: state_nx = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            shreg       <= '0;
            fill        <= '0;
            hold        <= '0;
            score       <= '0;
            score_valid <= 1'b0;
            match       <= 1'b0;
            hit_count   <= '0;
        end else if (clear) begin
            state       <= FILL;
            shreg       <= '0;
            fill        <= '0;
            hold        <= '0;
            score       <= '0;
            score_valid <= 1'b0;
            match       <= 1'b0;
            hit_count   <= '0;
        end else begin
            state       <= state_nx;
            hold        <= hold_n;
            score_valid <= eval;
            match       <= hit;
            if (bit_valid) begin
                shreg <= shreg_n;
                fill  <= fill_n;
            end
            if (eval) score <= score_n;
            if (hit && (hit_count != '1)) hit_count <= hit_count + 1'b1;
        end
    end

    assign state_o = state;
endmodule

// File: tb/tb_xnor_stream_correlator.sv
// Bench for xnor_stream_correlator: two instances (default, and CW=2/HOLDOFF=0/thresh=0)
// fed the same stream and compared each cycle against a window/counter model.
module tb_xnor_stream_correlator;
    logic       clk = 1'b0;
    logic       rst_n, clear, bit_valid, bit_in;
    logic [7:0] pattern;
    logic [3:0] thresh_a, thresh_b;
    logic [3:0] score_a, score_b;
    logic       sv_a, sv_b, match_a, match_b;
    logic [7:0] hit_a;
    logic [1:0] hit_b;
    logic [1:0] st_a, st_b;

    int tests = 0, fails = 0;

    // model state per instance
    int         n_m[2], hl_m[2], hits_m[2], sc_m[2];
    logic [7:0] win_m[2];
    bit         sv_m[2], m_m[2];
    int         hold_p[2] = '{8, 0};
    int         hmax[2]   = '{255, 3};

    always #5 clk = ~clk;

    xnor_stream_correlator #(.W(8), .HOLDOFF(8), .CW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bit_valid(bit_valid), .bit_in(bit_in),
        .pattern(pattern), .thresh(thresh_a), .score(score_a), .score_valid(sv_a),
        .match(match_a), .hit_count(hit_a), .state_o(st_a));

    xnor_stream_correlator #(.W(8), .HOLDOFF(0), .CW(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bit_valid(bit_valid), .bit_in(bit_in),
        .pattern(pattern), .thresh(thresh_b), .score(score_b), .score_valid(sv_b),
        .match(match_b), .hit_count(hit_b), .state_o(st_b));

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int agree(input logic [7:0] w, input logic [7:0] p);
        int c = 0;
        for (int i = 0; i < 8; i++) if (w[i] == p[i]) c++;
        return c;
    endfunction

    function automatic int exp_state(input int d);
        if (n_m[d] < 8) return 0;
        return (hl_m[d] > 0) ? 2 : 1;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            n_m[d] = 0; hl_m[d] = 0; hits_m[d] = 0; sc_m[d] = 0;
            win_m[d] = '0; sv_m[d] = 0; m_m[d] = 0;
        end
    endtask

    task automatic model_step(input logic v, input logic b, input logic c);
        int th;
        if (c) begin
            model_clear();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            th = (d == 0) ? int'(thresh_a) : int'(thresh_b);
            sv_m[d] = 0; m_m[d] = 0;
            if (v) begin
                win_m[d] = {win_m[d][6:0], b};
                if (n_m[d] < 8) n_m[d]++;
                if (n_m[d] == 8) begin
                    sc_m[d] = agree(win_m[d], pattern);
                    sv_m[d] = 1;
                    if (hl_m[d] > 0) hl_m[d]--;
                    else if (sc_m[d] >= th) begin
                        m_m[d] = 1;
                        if (hits_m[d] < hmax[d]) hits_m[d]++;
                        hl_m[d] = hold_p[d];
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("a_score", score_a, sc_m[0]);
        chk("a_sv", sv_a, sv_m[0]);
        chk("a_match", match_a, m_m[0]);
        chk("a_hits", hit_a, hits_m[0]);
        chk("a_state", st_a, exp_state(0));
        chk("b_score", score_b, sc_m[1]);
        chk("b_sv", sv_b, sv_m[1]);
        chk("b_match", match_b, m_m[1]);
        chk("b_hits", hit_b, hits_m[1]);
        chk("b_state", st_b, exp_state(1));
    endtask

    task automatic step(input logic v, input logic b, input logic c);
        @(negedge clk);
        bit_valid = v; bit_in = b; clear = c;
        @(posedge clk);
        #1;
        model_step(v, b, c);
        check_all();
        bit_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] x);
        for (int i = 7; i >= 0; i--) step(1'b1, x[i], 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pb;
        rst_n = 1'b1; clear = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        pattern = 8'hB4; thresh_a = 4'd8; thresh_b = 4'd0;
        model_clear();
        do_reset();

        // 7 bits leave the window unfilled, the 8th completes a perfect match
        pb = 8'hB4;
        for (int i = 7; i >= 1; i--) begin
            step(1'b1, pb[i], 1'b0);
            chk("t1_nosv", sv_a, 0);
            chk("t1_fill", st_a, 0);
        end
        step(1'b1, pb[0], 1'b0);
        chk("t2_sv", sv_a, 1);
        chk("t2_score", score_a, 8);
        chk("t2_match", match_a, 1);
        chk("t2_hits", hit_a, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("t2_hold", st_a, 2);
        chk("t6_gap_sv", sv_b, 0);

        // back-to-back pattern: bit 16 suppressed, bit 24 matches
        send_byte(8'hB4);
        chk("t3_sup", match_a, 0);
        send_byte(8'hB4);
        chk("t3_match", match_a, 1);
        chk("t3_hits", hit_a, 2);
        chk("t6_sat", hit_b, 3);

        // one-bit mismatch against thresholds 7 and 8
        step(1'b0, 1'b0, 1'b1);
        thresh_a = 4'd7;
        send_byte(8'hB5);
        chk("t4_score7", score_a, 7);
        chk("t4_match7", match_a, 1);
        step(1'b0, 1'b0, 1'b1);
        thresh_a = 4'd8;
        send_byte(8'hB5);
        chk("t4_score8", score_a, 7);
        chk("t4_nomatch8", match_a, 0);

        // reset mid-window, then clear mid-window (clear beats bit_valid)
        for (int i = 7; i >= 3; i--) step(1'b1, pb[i], 1'b0);
        do_reset();
        chk("t5_rst_hits", hit_a, 0);
        chk("t5_rst_state", st_a, 0);
        send_byte(8'hB4);
        chk("t5_rst_match", match_a, 1);
        for (int i = 7; i >= 3; i--) step(1'b1, pb[i], 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("t5_clr_sv", sv_a, 0);
        chk("t5_clr_hits", hit_a, 0);
        for (int i = 7; i >= 1; i--) step(1'b1, pb[i], 1'b0);
        chk("t5_clr_nomatch", match_a, 0);
        step(1'b1, pb[0], 1'b0);
        chk("t5_clr_match", match_a, 1);

        // randomized stream with gaps, occasional clears and pattern/threshold changes
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 15) == 0) thresh_a = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 63) == 0) pattern = 8'($urandom);
            step(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 99) < 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
